// File: rtl/axi_sram_responder.sv
// AXI4-Lite responder in front of a word-addressed SRAM, independent read/write FSMs.
// Optional AXI_SRAM_RAND_DELAY_EN adds LFSR-driven extra response latency.
module axi_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned WRITE_LAT   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  function automatic logic hit(input logic [31:0] a);
    return (a >= ADDR_BASE) && ((a - ADDR_BASE) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  logic [4:0]  r_lat_load;
  logic [4:0]  w_lat_load;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : '0);
  end

  assign r_lat_load = 5'(READ_LAT) + 5'(lfsr[3:0]);
  assign w_lat_load = 5'(WRITE_LAT) + 5'(lfsr[7:4]);
`else
  assign r_lat_load = 5'(READ_LAT);
  assign w_lat_load = 5'(WRITE_LAT);
`endif

  // ---------------- read path ----------------
  r_state_t    r_state, r_next;
  logic [4:0]  r_cnt;
  logic [31:0] ar_addr_q;
  logic [31:0] r_src;
  logic        r_sample;

  // A zero-latency read samples straight from the live address bus.
  assign r_src = (r_state == R_IDLE) ? araddr : ar_addr_q;

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next   = r_state;
    arready  = 1'b0;
    rvalid   = 1'b0;
    r_sample = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          if (r_lat_load == 5'd0) begin
            r_next   = R_RESP;
            r_sample = 1'b1;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt == 5'd1) begin
          r_next   = R_RESP;
          r_sample = 1'b1;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      ar_addr_q <= '0;
      rdata     <= '0;
      rresp     <= 2'b00;
    end else begin
      if (arready && arvalid) begin
        ar_addr_q <= araddr;
        r_cnt     <= r_lat_load;
      end else if (r_state == R_WAIT) begin
        r_cnt <= r_cnt - 5'd1;
      end
      if (r_sample) begin
        rdata <= hit(r_src) ? mem[word_idx(r_src)] : '0;
        rresp <= hit(r_src) ? 2'b00 : 2'b11;
      end
    end
  end

  // ---------------- write path ----------------
  w_state_t    w_state, w_next;
  logic [4:0]  w_cnt;
  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_fire, w_fire, w_load, w_commit;
  logic [31:0] c_addr, c_data;
  logic [3:0]  c_strb;

  // Channels not yet latched are taken from the bus so a same-cycle capture can commit.
  assign c_addr = aw_held ? aw_addr_q : awaddr;
  assign c_data = w_held  ? wdata_q   : wdata;
  assign c_strb = w_held  ? wstrb_q   : wstrb;

  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next   = w_state;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    aw_fire  = 1'b0;
    w_fire   = 1'b0;
    w_load   = 1'b0;
    w_commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = !aw_held;
        wready  = !w_held;
        aw_fire = awvalid && !aw_held;
        w_fire  = wvalid && !w_held;
        if ((aw_held || aw_fire) && (w_held || w_fire)) begin
          w_load = 1'b1;
          if (w_lat_load == 5'd0) begin
            w_next   = W_RESP;
            w_commit = 1'b1;
          end else begin
            w_next = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt == 5'd1) begin
          w_next   = W_RESP;
          w_commit = 1'b1;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      w_cnt     <= '0;
      bresp     <= 2'b00;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (w_load)                 w_cnt <= w_lat_load;
      else if (w_state == W_WAIT) w_cnt <= w_cnt - 5'd1;
      if (w_commit) bresp <= hit(c_addr) ? 2'b00 : 2'b11;
      if (bvalid && bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Non-blocking update keeps a same-edge read sample on the old word.
  always_ff @(posedge clock) begin
    if (w_commit && !reset && hit(c_addr)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (c_strb[i]) mem[word_idx(c_addr)][8*i +: 8] <= c_data[8*i +: 8];
      end
    end
  end

`ifndef SYNTHESIS
  logic        ar_stall_q, aw_stall_q, w_stall_q;
  logic [31:0] araddr_q, awaddr_q, wdata_chk_q;
  logic [3:0]  wstrb_chk_q;

  always_ff @(posedge clock) begin
    ar_stall_q  <= !reset && arvalid && !arready;
    aw_stall_q  <= !reset && awvalid && !awready;
    w_stall_q   <= !reset && wvalid && !wready;
    araddr_q    <= araddr;
    awaddr_q    <= awaddr;
    wdata_chk_q <= wdata;
    wstrb_chk_q <= wstrb;
  end

  always_ff @(posedge clock) begin
    if (!reset && ar_stall_q)
      assert (araddr == araddr_q) else $error("araddr changed while AR stalled");
    if (!reset && aw_stall_q)
      assert (awaddr == awaddr_q) else $error("awaddr changed while AW stalled");
    if (!reset && w_stall_q)
      assert (wdata == wdata_chk_q && wstrb == wstrb_chk_q) else $error("W payload changed while stalled");
  end
`endif

endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a word-array reference model.
module tb_axi_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned RL    = 1;
  localparam int unsigned WL    = 1;
  localparam logic [31:0] RB    = BASE + 32'h100;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int vectors = 0;
  int miscompares = 0;

  axi_sram_responder #(
    .ADDR_BASE(BASE),
    .DEPTH_WORDS(DEPTH),
    .READ_LAT(RL),
    .WRITE_LAT(WL)
  ) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
    vec_t v;
    v.name = n; v.is_write = w; v.addr = a; v.data = d; v.strb = s;
    v.exp_data = ed; v.exp_resp = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, input int unsigned hold,
                         output logic [31:0] d, output logic [1:0] r);
    bit hs;
    logic rdy;
    int unsigned lat;
    hs = 0; d = '0; r = '0;
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 40 && !hs; n++) begin
      rdy = arready;
      tick();
      hs = rdy;
    end
    arvalid = 1'b0;
    if (!hs) begin
      check("ar_timeout", 32'd0, 32'd1);
      return;
    end
    lat = 1;
    while (!rvalid && lat < 64) begin
      tick();
      lat++;
    end
    if (!rvalid) begin
      check("r_timeout", 32'd0, 32'd1);
      return;
    end
`ifndef AXI_SRAM_RAND_DELAY_EN
    check("r_latency", 32'(lat), 32'(RL + 1));
`endif
    d = rdata; r = rresp;
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      check("r_hold_valid", {31'd0, rvalid}, 32'd1);
      check("r_hold_data", rdata, d);
      check("r_hold_resp", 32'(rresp), 32'(r));
      check("r_hold_arready", {31'd0, arready}, 32'd0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("r_done_rvalid_arready", {30'd0, rvalid, arready}, 32'b01);
  endtask

  // aw_off > 0: W leads AW by aw_off cycles; aw_off < 0: AW leads W.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_off, output logic [1:0] resp);
    bit aw_done, w_done;
    logic awr, wr;
    int cyc, aw_start, w_start, n;
    aw_done = 0; w_done = 0; cyc = 0; resp = '0;
    aw_start = (aw_off > 0) ? aw_off : 0;
    w_start  = (aw_off < 0) ? -aw_off : 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_start);
      wvalid  = !w_done && (cyc >= w_start);
      if (w_done) check("wready_after_w", {31'd0, wready}, 32'd0);
      awr = awready; wr = wready;
      tick();
      if (awvalid && awr) aw_done = 1;
      if (wvalid && wr)   w_done  = 1;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      check("aw_w_timeout", 32'd0, 32'd1);
      return;
    end
    n = 0;
    while (!bvalid && n < 64) begin
      check("wready_wait", {31'd0, wready}, 32'd0);
      tick();
      n++;
    end
    if (!bvalid) begin
      check("b_timeout", 32'd0, 32'd1);
      return;
    end
`ifndef AXI_SRAM_RAND_DELAY_EN
    check("b_latency", 32'(n), 32'(WL));
`endif
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_done_bvalid_awready_wready", {29'd0, bvalid, awready, wready}, 32'b011);
  endtask

  logic [31:0] ref_mem [16];

  initial begin
    logic [31:0] rd, rd2, a, d;
    logic [1:0]  rr, rr2, br;
    logic [3:0]  s;
    bit          oor;
    int unsigned w;
    int          off;

    reset = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) tick();
    check("reset_handshakes", {27'd0, arready, awready, wready, rvalid, bvalid}, 32'b11100);
    check("reset_rdata", rdata, 32'd0);
    check("reset_resps", {28'd0, rresp, bresp}, 32'd0);
    reset = 1'b0;
    tick();

    add("wr_deadbeef",   1, BASE + 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        2'b00);
    add("rd_deadbeef",   0, BASE + 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 2'b00);
    add("rd_unaligned",  0, BASE + 32'h13,   32'h0,        4'h0, 32'hDEADBEEF, 2'b00);
    add("wr_full_20",    1, BASE + 32'h20,   32'h11223344, 4'hF, 32'h0,        2'b00);
    add("wr_part_20",    1, BASE + 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        2'b00);
    add("rd_part_20",    0, BASE + 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 2'b00);
    add("wr_full_24",    1, BASE + 32'h24,   32'h55667788, 4'hF, 32'h0,        2'b00);
    add("wr_nostrb_24",  1, BASE + 32'h24,   32'hFFFFFFFF, 4'h0, 32'h0,        2'b00);
    add("rd_nostrb_24",  0, BASE + 32'h24,   32'h0,        4'h0, 32'h55667788, 2'b00);
    add("wr_word0",      1, BASE,            32'h0BADC0DE, 4'hF, 32'h0,        2'b00);
    add("wr_last",       1, BASE + 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h0,        2'b00);
    add("rd_below",      0, 32'h7FFF_FFFC,   32'h0,        4'h0, 32'h0,        2'b11);
    add("wr_above",      1, BASE + 32'h1000, 32'h01234567, 4'hF, 32'h0,        2'b11);
    add("rd_above",      0, BASE + 32'h1000, 32'h0,        4'h0, 32'h0,        2'b11);
    add("rd_last",       0, BASE + 32'hFFC,  32'h0,        4'h0, 32'hCAFEF00D, 2'b00);
    add("rd_word0",      0, BASE,            32'h0,        4'h0, 32'h0BADC0DE, 2'b00);

    foreach (vecs[i]) begin
      if (vecs[i].is_write) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, br);
        check({vecs[i].name, "_bresp"}, 32'(br), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, 0, rd, rr);
        check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_data);
        check({vecs[i].name, "_rresp"}, 32'(rr), 32'(vecs[i].exp_resp));
      end
    end

    // W three cycles ahead of AW, then same cycle, then AW ahead of W
    do_write(BASE + 32'h30, 32'h0F0F0F0F, 4'hF, 3, br);
    check("order_w_first_bresp", 32'(br), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("order_single_b", {31'd0, bvalid}, 32'd0);
    end
    do_write(BASE + 32'h30, 32'h5A5A5A5A, 4'h3, 0, br);
    check("order_same_bresp", 32'(br), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("order_single_b2", {31'd0, bvalid}, 32'd0);
    end
    do_read(BASE + 32'h30, 0, rd, rr);
    check("order_readback", rd, 32'h0F0F5A5A);
    do_write(BASE + 32'h30, 32'h77000000, 4'h8, -2, br);
    do_read(BASE + 32'h30, 0, rd, rr);
    check("order_aw_first_readback", rd, 32'h770F5A5A);

    // rready held low for five cycles after rvalid
    do_read(BASE + 32'h10, 5, rd, rr);
    check("bp_rdata", rd, 32'hDEADBEEF);
    check("bp_rresp", 32'(rr), 32'd0);

    // read sample and write commit on the same edge, same word
    do_write(BASE + 32'h40, 32'h01010101, 4'hF, 0, br);
    fork
      do_read(BASE + 32'h40, 0, rd, rr);
      do_write(BASE + 32'h40, 32'h02020202, 4'hF, 0, br);
    join
    check("collide_old_data", rd, 32'h01010101);
    check("collide_bresp", 32'(br), 32'd0);
    do_read(BASE + 32'h40, 0, rd, rr);
    check("collide_new_data", rd, 32'h02020202);

    // reset during W_WAIT drops the write
    do_write(BASE + 32'h44, 32'h12345678, 4'hF, 0, br);
    awaddr = BASE + 32'h44; wdata = 32'h9ABCDEF0; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("rst_in_wait", {29'd0, awready, wready, bvalid}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_after", {29'd0, awready, wready, bvalid}, 32'b110);
    tick();
    check("rst_no_b", {31'd0, bvalid}, 32'd0);
    do_read(BASE + 32'h44, 0, rd, rr);
    check("rst_no_commit", rd, 32'h12345678);

    // randomized traffic over a 16-word region plus out-of-range addresses
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      ref_mem[i] = d;
      do_write(RB + 32'(4 * i), d, 4'hF, 0, br);
    end
    for (int k = 0; k < 80; k++) begin
      w   = $urandom_range(0, 15);
      oor = ($urandom_range(0, 7) == 0);
      if (oor) begin
        if ($urandom_range(0, 1) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
        else                           a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      end else begin
        a = RB + 32'(4 * w);
      end
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d   = $urandom;
        s   = 4'($urandom_range(0, 15));
        off = int'($urandom_range(0, 4)) - 2;
        do_write(a, d, s, off, br);
        check("rnd_bresp", 32'(br), oor ? 32'd3 : 32'd0);
        if (!oor) begin
          for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
          end
        end
      end else begin
        do_read(a, $urandom_range(0, 3), rd2, rr2);
        check("rnd_rdata", rd2, oor ? 32'd0 : ref_mem[w]);
        check("rnd_rresp", 32'(rr2), oor ? 32'd3 : 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
